// File: rtl/bresenham_pkg.sv
// ---------------------------------------------------------------------------
// bresenham_pkg
// Shared types and helpers for the Bresenham line rasteriser.
//   coord_t           : unsigned grid coordinate at the default width
//   err_t             : signed error/delta term, two bits wider than coord_t
//   bresenham_state_t : engine states IDLE -> INIT -> EMIT
//   abs_diff()        : |a - b| on unsigned operands
//   step_up()         : 1 when the walk from 'from_c' to 'to_c' increases
// ---------------------------------------------------------------------------
package bresenham_pkg;

   localparam int unsigned DEF_COORD_W  = 10;
   localparam int unsigned DEF_GRID_DIM = 1024;

   typedef logic [DEF_COORD_W-1:0]        coord_t;
   typedef logic signed [DEF_COORD_W+1:0] err_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      EMIT = 2'd2
   } bresenham_state_t;

   // Absolute difference of two unsigned values, never wraps.
   function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      if (a >= b) begin
         return a - b;
      end else begin
         return b - a;
      end
   endfunction

   // Direction of travel along one axis: 1 = +1 step, 0 = -1 step.
   function automatic logic step_up(input logic [31:0] from_c, input logic [31:0] to_c);
      return (to_c > from_c);
   endfunction

endpackage : bresenham_pkg

// File: rtl/bresenham_line.sv
// ---------------------------------------------------------------------------
// bresenham_line
// Rasterises one beam from the robot cell (x0,y0) to the scan endpoint
// (x1,y1) and streams the traversed cells over a valid/ready handshake.
// The endpoint cell carries point_last so the grid marks it occupied.
//
// Ports:
//   clock        in   system clock, posedge
//   reset_n      in   asynchronous active-low reset
//   start        in   one-cycle request, sampled only in IDLE
//   x0,y0        in   line start (robot cell), captured with start
//   x1,y1        in   line end (scan endpoint), captured with start
//   busy         out  registered; high from the cycle after start is
//                     accepted until the last cell handshakes
//   point_valid  out  point_x/point_y hold a valid cell
//   point_ready  in   downstream accepts the cell this cycle
//   point_x/y    out  current cell
//   point_last   out  current cell is the endpoint (qualified by valid)
//
// Build option:
//   BRESENHAM_BOUNDS_CHECK_EN - when defined, cells outside GRID_DIM are
//   not presented; the engine steps past them internally. An out-of-range
//   endpoint ends the line silently.
// ---------------------------------------------------------------------------
module bresenham_line
   import bresenham_pkg::*;
#(
   parameter int unsigned COORD_W  = DEF_COORD_W,
   parameter int unsigned GRID_DIM = DEF_GRID_DIM
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   output logic               busy,
   output logic               point_valid,
   input  logic               point_ready,
   output logic [COORD_W-1:0] point_x,
   output logic [COORD_W-1:0] point_y,
   output logic               point_last
);

   // Error terms are two bits wider than a coordinate so |dx|+|dy| and
   // 2*err never overflow.
   localparam int unsigned EW = COORD_W + 2;

`ifdef BRESENHAM_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
   localparam logic signed [EW-1:0] ERR_ZERO = '0;

   // With the bounds check disabled every cell counts as inside the grid.
   function automatic logic in_grid(input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
      return (!BOUNDS_EN) || ((32'(cx) < GRID_DIM) && (32'(cy) < GRID_DIM));
   endfunction

   bresenham_state_t      state_q, state_d;
   logic [COORD_W-1:0]    x0_q, x0_d;
   logic [COORD_W-1:0]    y0_q, y0_d;
   logic [COORD_W-1:0]    x1_q, x1_d;
   logic [COORD_W-1:0]    y1_q, y1_d;
   logic [COORD_W-1:0]    cur_x_q, cur_x_d;
   logic [COORD_W-1:0]    cur_y_q, cur_y_d;
   logic signed [EW-1:0]  dx_q, dx_d;
   logic signed [EW-1:0]  dy_q, dy_d;
   logic signed [EW-1:0]  err_q, err_d;
   logic                  sx_pos_q, sx_pos_d;
   logic                  sy_pos_q, sy_pos_d;
   logic                  busy_q, busy_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   // at_end_q tracks "cur is the endpoint" independently of whether the
   // cell is visible, so a suppressed endpoint still terminates the line.
   logic                  at_end_q, at_end_d;

   logic signed [EW-1:0]  e2_s;
   logic                  step_x_s;
   logic                  step_y_s;
   logic [COORD_W-1:0]    nx_s;
   logic [COORD_W-1:0]    ny_s;
   logic signed [EW-1:0]  err_nx_s;
   logic                  adv_s;

   // One Bresenham step computed from the current (pre-step) error.
   always_comb begin
      e2_s     = err_q <<< 1;
      step_x_s = (e2_s >= dy_q);
      step_y_s = (e2_s <= dx_q);
      if (step_x_s) begin
         nx_s = sx_pos_q ? (cur_x_q + ONE) : (cur_x_q - ONE);
      end else begin
         nx_s = cur_x_q;
      end
      if (step_y_s) begin
         ny_s = sy_pos_q ? (cur_y_q + ONE) : (cur_y_q - ONE);
      end else begin
         ny_s = cur_y_q;
      end
      err_nx_s = err_q + (step_x_s ? dy_q : ERR_ZERO) + (step_y_s ? dx_q : ERR_ZERO);
      // A hidden cell advances on its own; a visible one waits for ready.
      adv_s    = valid_q ? point_ready : 1'b1;
   end

   // Next-state and datapath control for IDLE / INIT / EMIT.
   always_comb begin
      state_d  = state_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      x1_d     = x1_q;
      y1_d     = y1_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      err_d    = err_q;
      sx_pos_d = sx_pos_q;
      sy_pos_d = sy_pos_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      last_d   = last_q;
      at_end_d = at_end_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               x0_d    = x0;
               y0_d    = y0;
               x1_d    = x1;
               y1_d    = y1;
               busy_d  = 1'b1;
               state_d = INIT;
            end else begin
               state_d = IDLE;
            end
         end

         INIT: begin
            dx_d     = $signed(EW'(abs_diff(32'(x0_q), 32'(x1_q))));
            dy_d     = -$signed(EW'(abs_diff(32'(y0_q), 32'(y1_q))));
            sx_pos_d = step_up(32'(x0_q), 32'(x1_q));
            sy_pos_d = step_up(32'(y0_q), 32'(y1_q));
            err_d    = dx_d + dy_d;
            cur_x_d  = x0_q;
            cur_y_d  = y0_q;
            at_end_d = (x0_q == x1_q) && (y0_q == y1_q);
            valid_d  = in_grid(x0_q, y0_q);
            last_d   = at_end_d && valid_d;
            state_d  = EMIT;
         end

         EMIT: begin
            if (adv_s) begin
               if (at_end_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  cur_x_d  = nx_s;
                  cur_y_d  = ny_s;
                  err_d    = err_nx_s;
                  at_end_d = (nx_s == x1_q) && (ny_s == y1_q);
                  valid_d  = in_grid(nx_s, ny_s);
                  last_d   = at_end_d && valid_d;
               end
            end else begin
               // Stalled by the consumer: hold everything.
               state_d = EMIT;
            end
         end

         default: begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            at_end_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         err_q    <= '0;
         sx_pos_q <= 1'b0;
         sy_pos_q <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         at_end_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         err_q    <= err_d;
         sx_pos_q <= sx_pos_d;
         sy_pos_q <= sy_pos_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         at_end_q <= at_end_d;
      end
   end

   assign busy        = busy_q;
   assign point_valid = valid_q;
   assign point_x     = cur_x_q;
   assign point_y     = cur_y_q;
   assign point_last  = last_q;

endmodule : bresenham_line

// File: tb/tb_bresenham_line.sv
// ---------------------------------------------------------------------------
// tb_bresenham_line
// Directed bench for bresenham_line. Stimulus pushes hand-computed cells
// into a queue; an independent monitor pops and compares on each handshake
// and also checks that a stalled cell stays stable.
// ---------------------------------------------------------------------------
module tb_bresenham_line;

   localparam int CW = 10;
`ifdef BRESENHAM_BOUNDS_CHECK_EN
   localparam int GD = 8;
`else
   localparam int GD = 1024;
`endif

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic          busy, point_valid, point_last;
   logic          point_ready = 1'b0;
   logic [CW-1:0] point_x, point_y;

   bresenham_line #(.COORD_W(CW), .GRID_DIM(GD)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .x0          (x0),
      .y0          (y0),
      .x1          (x1),
      .y1          (y1),
      .busy        (busy),
      .point_valid (point_valid),
      .point_ready (point_ready),
      .point_x     (point_x),
      .point_y     (point_y),
      .point_last  (point_last)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          last;
   } cell_t;

   cell_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input int cx, input int cy, input logic lst);
      cell_t c;
      c.x    = CW'(cx);
      c.y    = CW'(cy);
      c.last = lst;
      exp_q.push_back(c);
   endtask

   // Monitor: compare every handshaken cell against the queue head.
   initial begin : monitor
      logic  stall;
      cell_t held;
      cell_t e;
      stall = 1'b0;
      held  = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            stall = 1'b0;
         end else if (point_valid) begin
            if (stall) begin
               chk("hold_x", point_x, held.x);
               chk("hold_y", point_y, held.y);
               chk("hold_last", point_last, held.last);
            end
            if (point_ready) begin
               stall = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_cell", point_valid, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("cell_x", point_x, e.x);
                  chk("cell_y", point_y, e.y);
                  chk("cell_last", point_last, e.last);
               end
            end else begin
               stall = 1'b1;
               held  = {point_x, point_y, point_last};
            end
         end else begin
            stall = 1'b0;
         end
      end
   end

   task automatic do_start(input int ax0, input int ay0, input int ax1, input int ay1);
      @(posedge clock);
      #1;
      x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Count busy cycles after the start cycle; optionally toggle ready and
   // re-pulse start with foreign coordinates at cycle restart_at.
   task automatic run(input logic tog, input int restart_at,
                      output int busy_cyc, output int first_valid);
      busy_cyc    = 0;
      first_valid = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clock);
         if (!busy) break;
         busy_cyc = busy_cyc + 1;
         if (point_valid && (first_valid == 0)) first_valid = i;
         @(posedge clock);
         #1;
         if (tog) point_ready = ~point_ready;
         if (i == restart_at) begin
            x0 = CW'(9); y0 = CW'(9); x1 = CW'(1); y1 = CW'(1);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("busy_timeout", busy, 1'b0);
   endtask

   initial begin : stim
      int bc, fv;
      // Reset values while reset is held.
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", point_valid, 1'b0);
      chk("rst_last", point_last, 1'b0);
      chk("rst_x", point_x, 0);
      chk("rst_y", point_y, 0);
      @(posedge clock);
      #1;
      reset_n     = 1'b1;
      point_ready = 1'b1;

      // Shallow diagonal (0,0)->(4,2).
      push(0, 0, 1'b0); push(1, 1, 1'b0); push(2, 1, 1'b0);
      push(3, 2, 1'b0); push(4, 2, 1'b1);
      do_start(0, 0, 4, 2);
      run(1'b0, 0, bc, fv);
      chk("diag_busy_cycles", bc, 6);
      chk("diag_first_valid", fv, 2);

      // Degenerate single-cell line.
      push(5, 5, 1'b1);
      do_start(5, 5, 5, 5);
      run(1'b0, 0, bc, fv);
      chk("point_busy_cycles", bc, 2);
      chk("point_first_valid", fv, 2);

      // Horizontal line walking towards negative x.
      for (int k = 7; k >= 2; k--) push(k, 3, (k == 2));
      do_start(7, 3, 2, 3);
      run(1'b0, 0, bc, fv);
      chk("negx_busy_cycles", bc, 7);

      // Same line with ready toggling every cycle.
      for (int k = 7; k >= 2; k--) push(k, 3, (k == 2));
      do_start(7, 3, 2, 3);
      run(1'b1, 0, bc, fv);
      point_ready = 1'b1;
      chk("toggle_drained", exp_q.size(), 0);

      // Mid-line reset after the 10th cell of (0,0)->(100,40).
      push(0, 0, 1'b0); push(1, 0, 1'b0); push(2, 1, 1'b0); push(3, 1, 1'b0);
      push(4, 2, 1'b0); push(5, 2, 1'b0); push(6, 2, 1'b0); push(7, 3, 1'b0);
      push(8, 3, 1'b0); push(9, 4, 1'b0);
      do_start(0, 0, 100, 40);
      for (int i = 0; i < 200; i++) begin
         @(posedge clock);
         if (exp_q.size() == 0) break;
      end
      chk("reset_wait_drained", exp_q.size(), 0);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_valid", point_valid, 1'b0);
      repeat (2) @(posedge clock);
      #2;
      reset_n = 1'b1;
      repeat (3) @(posedge clock);
      push(1, 1, 1'b0); push(1, 2, 1'b0); push(1, 3, 1'b1);
      do_start(1, 1, 1, 3);
      run(1'b0, 0, bc, fv);
      chk("vert_busy_cycles", bc, 4);

      // start re-pulsed while busy must be ignored.
      push(0, 0, 1'b0); push(1, 1, 1'b0); push(2, 1, 1'b0);
      push(3, 2, 1'b0); push(4, 2, 1'b1);
      do_start(0, 0, 4, 2);
      run(1'b0, 2, bc, fv);
      chk("restart_busy_cycles", bc, 6);
      repeat (4) @(posedge clock);
      chk("restart_stays_idle", busy, 1'b0);

`ifdef BRESENHAM_BOUNDS_CHECK_EN
      // Line leaving an 8x8 grid: only in-range cells, no point_last.
      push(5, 0, 1'b0); push(6, 0, 1'b0); push(7, 0, 1'b0);
      do_start(5, 0, 10, 0);
      run(1'b0, 0, bc, fv);
      chk("bounds_busy_cycles", bc, 7);
      chk("bounds_first_valid", fv, 2);
`endif

      repeat (3) @(posedge clock);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bresenham_line

// File: doc/bresenham_line.md
Name: bresenham_line

Overview:
- Rasterises one laser beam into grid cells, from the robot cell (x0,y0) to the scan endpoint cell (x1,y1).
- Sits directly downstream of the mapping control unit, driven by its bresenham_start pulse and reporting through bresenham_busy.
- Streams cell indices to the occupancy-grid updater over a valid/ready handshake, one cell per handshake.
- The final cell (endpoint) is flagged so the grid marks it occupied; all earlier cells are marked free.

Parameters:
- COORD_W, 10, width of each unsigned grid coordinate.
- GRID_DIM, 1024, grid side length in cells, must be <= 2**COORD_W; used only by the optional feature.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- x0  in  COORD_W  line start x (robot cell); captured when start is accepted.
- y0  in  COORD_W  line start y; captured with start.
- x1  in  COORD_W  line end x (scan endpoint); captured with start.
- y1  in  COORD_W  line end y; captured with start.
- busy  out  1  high from the cycle after start is accepted until the last cell handshakes.
- point_valid  out  1  point_x/point_y hold a valid cell.
- point_ready  in  1  occupancy-grid updater accepts the cell this cycle.
- point_x  out  COORD_W  current cell x.
- point_y  out  COORD_W  current cell y.
- point_last  out  1  current cell is the endpoint (x1,y1); qualified by point_valid.

Behaviour:
- Reset (reset_n low, async): state IDLE; busy, point_valid, point_last = 0; point_x, point_y, error and delta registers = 0.
- States: IDLE, INIT, EMIT.
  - IDLE: on start=1, register x0/y0/x1/y1 and go to INIT. busy is registered, so it reads 1 on the very next cycle. This is required so the control unit's wait state never sees a false idle.
  - INIT (1 cycle):
    - dx = |x1-x0|, dy = -|y1-y0|.
    - sx = +1 if x1>x0 else -1; sy = +1 if y1>y0 else -1.
    - err = dx+dy.
    - cur = (x0,y0).
    - Go to EMIT.
  - EMIT:
    - point_valid=1; point_x/point_y = cur; point_last = (cur==(x1,y1)).
    - If point_valid && !point_ready: hold all outputs and registers stable.
    - On a handshake with point_last=1: go to IDLE; busy and point_valid drop the next cycle.
    - On a handshake otherwise: e2 = 2*err.
      - If e2 >= dy: err += dy, cur_x += sx.
      - If e2 <= dx: err += dx, cur_y += sy.
      - Both updates use the pre-step err, so diagonal steps happen in one cycle.
- Latency:
  - First cell is presented 2 cycles after the start cycle.
  - With point_ready held high, one cell per cycle.
  - Total cells = max(dx,|dy|)+1.
- Widths:
  - dx, dy, err and e2 are signed, COORD_W+2 bits, so no overflow occurs for any coordinate pair.
  - cur_x/cur_y never leave the [x0..x1]/[y0..y1] range.
- Boundary conditions:
  - Degenerate line (x0==x1, y0==y1): exactly one cell, with point_last=1.
  - Purely horizontal or vertical lines: only one axis steps.
  - start while busy: ignored; the captured coordinates are not disturbed.
  - start in the same cycle busy falls: accepted only if the state is IDLE in that cycle.
  - reset_n asserted mid-line: immediate abort to IDLE; no further cells emitted.
  - point_ready high while point_valid is low: no effect.

Optional Feature:
- Macro: BRESENHAM_BOUNDS_CHECK_EN.
- Defined:
  - Cells with cur_x >= GRID_DIM or cur_y >= GRID_DIM are suppressed: point_valid=0 and the engine steps internally as if handshaken.
  - The endpoint is never suppressed from termination. If it is out of range, the line ends silently with no point_last cell emitted, and busy drops.
- Undefined: every cell is emitted and GRID_DIM is unused.

Decomposition:
- Package bresenham_pkg holds:
  - typedef coord_t (logic [COORD_W-1:0] with default width);
  - typedef signed err_t (COORD_W+2 bits);
  - state enum bresenham_state_t {IDLE, INIT, EMIT}.
- No sub-module: the datapath and FSM fit in one module. An abs/sign helper function belongs in the package.

Test Plan:
- (0,0)->(4,2), ready=1:
  - cells (0,0),(1,0)... exactly (0,0),(1,1),(2,1),(3,2),(4,2);
  - point_last only on (4,2);
  - busy high for 6 cycles after the start cycle.
- (5,5)->(5,5): single cell (5,5) with point_last=1; busy high for exactly 2 cycles.
- (7,3)->(2,3) (negative x):
  - cells x=7,6,5,4,3,2 with y=3;
  - then point_ready toggles 1/0 each cycle: outputs are stable while ready=0, and no cell is duplicated or dropped.
- Mid-line reset: (0,0)->(100,40), reset_n pulsed low after the 10th cell → busy=0 and point_valid=0 immediately; a new start (1,1)->(1,3) yields (1,1),(1,2),(1,3).
- start re-pulsed while busy with different coordinates → ignored; the original line completes unchanged.
- With BRESENHAM_BOUNDS_CHECK_EN and GRID_DIM=8, line (5,0)->(10,0) → cells (5,0),(6,0),(7,0) emitted; no point_last; busy drops after the internal steps complete.
